// File: rtl/xswitch_pkg.sv
// Shared types and helpers for the xswitch ingress path.
package xswitch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xsw_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } ingress_state_t;

    function automatic logic is_onehot4(input logic [3:0] sel);
        logic r;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xswitch_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; DEPTH must be a power of two.
module xswitch_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W + 1)'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == DEPTH_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; the level counter disambiguates full/empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/xswitch_ingress_port.sv
// Ingress stage for one xswitch port: drops illegal destinations, buffers, registers output.
// Defining XSW_INGRESS_STATS_EN adds saturating drop_cnt / pkt_cnt outputs.
module xswitch_ingress_port
    import xswitch_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PORT_ID = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef XSW_INGRESS_STATS_EN
    ,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            pkt_cnt
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_param_check
        $error("xswitch_ingress_port: illegal DEPTH or PORT_ID");
    end

    ingress_state_t state;
    ingress_state_t state_next;
    xsw_word_t      in_word;
    xsw_word_t      head_word;
    xsw_word_t      stage_p1;
    logic           legal;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;

    assign in_word  = '{addr: in_addr, data: in_data};
    assign legal    = is_onehot4(in_addr[7:4]);
    assign in_ready = !fifo_full && reset;
    assign push     = in_valid && in_ready && legal;

    xswitch_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (xsw_word_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_word),
        .head  (head_word),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A pop always refills the output register in the same edge, so VALID streams one word per cycle.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- output stage p1 ----
    always_ff @(posedge clk) begin
        if (!reset)   stage_p1 <= '0;
        else if (pop) stage_p1 <= head_word;
    end

    assign out_valid = (state == VALID);
    assign out_addr  = stage_p1.addr;
    assign out_data  = stage_p1.data;

`ifdef XSW_INGRESS_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (in_valid && in_ready && !legal) drop_cnt <= sat_inc(drop_cnt);
            if (out_valid && out_ready)         pkt_cnt  <= sat_inc(pkt_cnt);
        end
    end
`endif

endmodule
